vfp_axil_cfg_regs: RTL and testbench

//  AXI4-Lite slave (responder) register file for the vfp configuration space; the target of PS/VIP master writes/reads.

---
 rtl/vfp_axil_cfg_regs.sv | 232 +++++++++++++++++++++++
 tb/tb_vfp_axil_cfg_regs.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vfp_axil_cfg_regs.sv
// ============================================================================
// Module      : vfp_axil_cfg_regs
// Description : AXI4-Lite register file for the vfp configuration space.
//               Optional macro VFP_CFG_WR_PULSE_EN adds per-register pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfp_axil_cfg_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] cfg_regs
`ifdef VFP_CFG_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]                  cfg_wr_pulse
`endif
);

    localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int SW   = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic            aw_full_q, aw_full_d;
    logic [IDXW-1:0] aw_idx_q, aw_idx_d;
    logic            w_full_q, w_full_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [SW-1:0]   w_strb_q, w_strb_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            ar_full_q, ar_full_d;
    logic [IDXW-1:0] ar_idx_q, ar_idx_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic [DW-1:0]   regs_d [NUM_REGS];

    logic            w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_err, w_rd_err;
    logic [31:0]     w_aw_idx32, w_ar_idx32;
    logic [DW-1:0]   w_rd_sel;
    logic            w_unused_ok;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_aw_hs    = S_AXI_AWVALID && awready_q;
    assign w_w_hs     = S_AXI_WVALID && wready_q;
    assign w_ar_hs    = S_AXI_ARVALID && arready_q;
    assign w_commit   = aw_full_q && w_full_q;
    assign w_aw_idx32 = 32'(aw_idx_q);
    assign w_ar_idx32 = 32'(ar_idx_q);
    assign w_wr_err   = (w_aw_idx32 >= NUM_REGS);
    assign w_rd_err   = (w_ar_idx32 >= NUM_REGS);

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx32 == i) begin
                w_rd_sel = regs_q[i];
            end
        end
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        ar_full_d = ar_full_q;
        ar_idx_d  = ar_idx_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (w_aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (w_commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_wr_err ? RESP_SLVERR : RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_aw_idx32 == i) begin
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Read data is captured from the current registers, so a same-cycle
        // commit to the same index is not visible in this response.
        if (ar_full_q) begin
            ar_full_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = w_rd_err ? '0 : w_rd_sel;
            rresp_d   = w_rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (w_ar_hs) begin
            ar_full_d = 1'b1;
            ar_idx_d  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end

        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
        arready_d = !ar_full_d && !rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ar_full_q <= 1'b0;
            ar_idx_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ar_full_q <= ar_full_d;
            ar_idx_q  <= ar_idx_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_regs[DW*g +: DW] = regs_q[g];
    end

`ifdef VFP_CFG_WR_PULSE_EN
    logic [NUM_REGS-1:0] pulse_q, pulse_d;

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_commit && !w_wr_err && (w_aw_idx32 == i)) begin
                pulse_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign cfg_wr_pulse = pulse_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vfp_axil_cfg_regs.sv
// Directed testbench for vfp_axil_cfg_regs (ADDR_WIDTH=5, NUM_REGS=4).
`default_nettype none

module tb_vfp_axil_cfg_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] cfg;
`ifdef VFP_CFG_WR_PULSE_EN
    logic [3:0]   pulse;
    logic [3:0]   last_pulse;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0]  resp;
    logic [31:0] data;

    always #5 clk = ~clk;

    vfp_axil_cfg_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_REGS           (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .cfg_regs      (cfg)
`ifdef VFP_CFG_WR_PULSE_EN
        ,
        .cfg_wr_pulse  (pulse)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 1'b0; w_done = 1'b0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            n++;
            if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", bvalid, 1'b1);
`ifdef VFP_CFG_WR_PULSE_EN
        last_pulse = pulse;
`endif
        r = bresp;
        tick();
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        bit hs;
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arvalid && arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", rvalid, 1'b1);
        d = rdata;
        r = rresp;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        repeat (3) tick();

        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cfg", cfg, 128'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);

        // Fill all four registers and read them back.
        for (int i = 0; i < 4; i++) begin
            axi_wr(5'(4 * i), 32'(i + 1), 4'hF, resp);
            chk("fill_bresp", resp, 2'b00);
        end
        chk("fill_cfg", cfg, {32'h4, 32'h3, 32'h2, 32'h1});
        for (int i = 0; i < 4; i++) begin
            axi_rd(5'(4 * i), data, resp);
            chk("fill_rdata", data, 32'(i + 1));
            chk("fill_rresp", resp, 2'b00);
        end

        // Byte strobes.
        axi_wr(5'h04, 32'hAABBCCDD, 4'hF, resp);
        axi_wr(5'h05, 32'h11223344, 4'b0101, resp);
        chk("strb_bresp", resp, 2'b00);
        axi_rd(5'h04, data, resp);
        chk("strb_rdata", data, 32'hAA22CC44);
        axi_wr(5'h04, 32'hFFFFFFFF, 4'b0000, resp);
        chk("strb0_bresp", resp, 2'b00);
        axi_rd(5'h07, data, resp);
        chk("strb0_rdata", data, 32'hAA22CC44);

        // Out-of-range index.
        axi_wr(5'h10, 32'hDEADBEEF, 4'hF, resp);
        chk("oor_bresp", resp, 2'b10);
        chk("oor_cfg", cfg, {32'h4, 32'h3, 32'hAA22CC44, 32'h1});
`ifdef VFP_CFG_WR_PULSE_EN
        chk("oor_no_pulse", last_pulse, 4'b0000);
`endif
        axi_rd(5'h14, data, resp);
        chk("oor_rdata", data, 32'h0);
        chk("oor_rresp", resp, 2'b10);

        // W ahead of AW, B throttled for five cycles.
        bready = 1'b0;
        wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
        chk("early_w_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        chk("early_w_awready", awready, 1'b1);
        chk("early_w_wready_busy", wready, 1'b0);
        awaddr = 5'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("late_aw_no_bvalid_yet", bvalid, 1'b0);
        tick();
        chk("late_aw_bvalid", bvalid, 1'b1);
        chk("late_aw_bresp", bresp, 2'b00);
        chk("late_aw_cfg", cfg, {32'h4, 32'h55, 32'hAA22CC44, 32'h1});
`ifdef VFP_CFG_WR_PULSE_EN
        chk("pulse_reg2", pulse, 4'b0100);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bhold_bvalid", bvalid, 1'b1);
            chk("bhold_awready", awready, 1'b0);
            chk("bhold_wready", wready, 1'b0);
`ifdef VFP_CFG_WR_PULSE_EN
            chk("pulse_gone", pulse, 4'b0000);
`endif
        end
        chk("bhold_cfg", cfg, {32'h4, 32'h55, 32'hAA22CC44, 32'h1});
        bready = 1'b1;
        tick();
        chk("bdone_bvalid", bvalid, 1'b0);
        chk("bdone_awready", awready, 1'b1);

        // Reset with both responses pending.
        bready = 1'b0; rready = 1'b0;
        awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        chk("pend_bvalid", bvalid, 1'b1);
        chk("pend_rvalid", rvalid, 1'b1);
        chk("pend_rdata", rdata, 32'hAA22CC44);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bvalid", bvalid, 1'b0);
        chk("arst_rvalid", rvalid, 1'b0);
        chk("arst_awready", awready, 1'b0);
        chk("arst_arready", arready, 1'b0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_cfg", cfg, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        axi_wr(5'h0C, 32'h9, 4'hF, resp);
        chk("after_rst_bresp", resp, 2'b00);
        axi_rd(5'h0C, data, resp);
        chk("after_rst_rdata", data, 32'h9);
        chk("after_rst_cfg", cfg, {32'h9, 96'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
